// File: rtl/projection_histogram_pkg.sv
// Shared definitions for the projection histogram: command codes, bin
// geometry, FSM encodings and the saturating increment used by every bin.
package projection_histogram_pkg;

    localparam int BINS  = 128;
    localparam int BIN_W = 16;
    localparam int IDX_W = 7;
    localparam int CMD_W = 16;

    localparam logic [CMD_W-1:0] CMD_NOOP  = 16'd0;
    localparam logic [CMD_W-1:0] CMD_START = 16'd1;
    localparam logic [CMD_W-1:0] CMD_STOP  = 16'd2;

    typedef enum logic {
        CTRL_IDLE,
        CTRL_RUN
    } ctrl_state_e;

    typedef enum logic [1:0] {
        HO_IDLE,
        HO_HOLD,
        HO_CLEAR
    } ho_state_e;

    // Bin increment that sticks at full scale instead of wrapping.
    function automatic logic [BIN_W-1:0] sat_inc(input logic [BIN_W-1:0] v);
        return (v == {BIN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/projection_histogram_bank.sv
// One histogram bank: 128 y-bins and 128 x-bins of saturating counters with a
// single-cycle clear and two zero-latency read ports. The one-cycle clear and
// the combinational reads rule out block RAM, so the bins live in flops.
module histogram_bank
    import projection_histogram_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_en_i,
    input  logic [IDX_W-1:0] inc_y_i,
    input  logic [IDX_W-1:0] inc_x_i,
    input  logic [IDX_W-1:0] rd_y_i,
    input  logic [IDX_W-1:0] rd_x_i,
    output logic [BIN_W-1:0] rd_y_data_o,
    output logic [BIN_W-1:0] rd_x_data_o
);

    logic [BIN_W-1:0] y_bins_q [BINS];
    logic [BIN_W-1:0] x_bins_q [BINS];

    // Bin storage: clear wins over increment; one hit bumps one y and one x bin.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            for (int i = 0; i < BINS; i++) begin
                y_bins_q[i] <= '0;
                x_bins_q[i] <= '0;
            end
        end else if (inc_en_i) begin
            y_bins_q[inc_y_i] <= sat_inc(y_bins_q[inc_y_i]);
            x_bins_q[inc_x_i] <= sat_inc(x_bins_q[inc_x_i]);
        end
    end

    assign rd_y_data_o = y_bins_q[rd_y_i];
    assign rd_x_data_o = x_bins_q[rd_x_i];

endmodule

// File: rtl/projection_histogram.sv
// Ping-pong projection histogram. Hits accumulate into the active bank for a
// fixed number of cycles; at the frame boundary the banks swap and the frozen
// bank is offered to the USB controller (start_sending) for a fixed window,
// after which it is wiped so it is clean when it becomes active again.
module projection_histogram
    import projection_histogram_pkg::*;
#(
    parameter int FRAME_CYCLES = 1000000,
    parameter int HOLD_CYCLES  = 130
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             event_valid,
    input  logic [IDX_W-1:0] event_y,
    input  logic [IDX_W-1:0] event_x,
    input  logic [CMD_W-1:0] command,
    input  logic [IDX_W-1:0] read_index_yaxis,
    input  logic [IDX_W-1:0] read_index_xaxis,
    output logic [BIN_W-1:0] data_yaxis,
    output logic [BIN_W-1:0] data_xaxis,
    output logic             start_sending,
    output logic             running,
    output logic [15:0]      frame_count
);

    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

    logic [CMD_W-1:0] prev_cmd_q;
    ctrl_state_e      ctrl_q, ctrl_d;
    ho_state_e        ho_q, ho_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             active_bank_q, active_bank_d;

    logic cmd_changed;
    logic start_cmd;
    logic stop_cmd;
    logic frame_end;
    logic ev_accept;
    logic clear_active;
    logic clear_frozen;

    // Commands are level-held; only the first cycle of a new value counts.
    assign cmd_changed = (command != prev_cmd_q);
    assign start_cmd   = cmd_changed && (command == CMD_START);
    assign stop_cmd    = cmd_changed && (command == CMD_STOP);

    // A START/STOP in the same cycle as a hit or a frame boundary takes
    // priority: the active bank is being wiped anyway.
    assign frame_end    = (ctrl_q == CTRL_RUN) && !start_cmd && !stop_cmd
                          && (frame_cnt_q == FRAME_LAST);
    assign ev_accept    = (ctrl_q == CTRL_RUN) && event_valid && !start_cmd && !stop_cmd;
    assign clear_active = start_cmd || (stop_cmd && (ctrl_q == CTRL_RUN));
    assign clear_frozen = (ho_q == HO_CLEAR);

    // Control FSM next state: run/idle, frame timing, bank swap, frame counter.
    always_comb begin
        ctrl_d        = ctrl_q;
        frame_cnt_d   = frame_cnt_q;
        frame_count_d = frame_count_q;
        active_bank_d = active_bank_q;
        case (ctrl_q)
            CTRL_IDLE: begin
                if (start_cmd) begin
                    ctrl_d        = CTRL_RUN;
                    frame_cnt_d   = '0;
                    frame_count_d = '0;
                end
            end
            CTRL_RUN: begin
                if (start_cmd) begin
                    frame_cnt_d   = '0;
                    frame_count_d = '0;
                end else if (stop_cmd) begin
                    ctrl_d      = CTRL_IDLE;
                    frame_cnt_d = '0;
                end else if (frame_end) begin
                    frame_cnt_d   = '0;
                    frame_count_d = frame_count_q + 16'd1;
                    active_bank_d = ~active_bank_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            default: ctrl_d = CTRL_IDLE;
        endcase
    end

    // Handoff FSM next state: hold the frozen bank for the reader, then wipe it.
    // Commands are deliberately not looked at here so a handoff always completes.
    always_comb begin
        ho_d       = ho_q;
        hold_cnt_d = hold_cnt_q;
        case (ho_q)
            HO_IDLE: begin
                if (frame_end) begin
                    ho_d       = HO_HOLD;
                    hold_cnt_d = '0;
                end
            end
            HO_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    ho_d = HO_CLEAR;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            HO_CLEAR: ho_d = HO_IDLE;
            default:  ho_d = HO_IDLE;
        endcase
    end

    // State registers for both FSMs and the command edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_cmd_q    <= '0;
            ctrl_q        <= CTRL_IDLE;
            ho_q          <= HO_IDLE;
            frame_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            frame_count_q <= '0;
            active_bank_q <= 1'b0;
        end else begin
            prev_cmd_q    <= command;
            ctrl_q        <= ctrl_d;
            ho_q          <= ho_d;
            frame_cnt_q   <= frame_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            frame_count_q <= frame_count_d;
            active_bank_q <= active_bank_d;
        end
    end

    logic [BIN_W-1:0] bank_y_rd [2];
    logic [BIN_W-1:0] bank_x_rd [2];

    // Two identical banks; their roles (active/frozen) follow active_bank_q.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic is_active;
        assign is_active = (active_bank_q == 1'(gi));

        histogram_bank u_bank (
            .clk         (clk),
            .reset       (reset),
            .clear_i     (is_active ? clear_active : clear_frozen),
            .inc_en_i    (is_active && ev_accept),
            .inc_y_i     (event_y),
            .inc_x_i     (event_x),
            .rd_y_i      (read_index_yaxis),
            .rd_x_i      (read_index_xaxis),
            .rd_y_data_o (bank_y_rd[gi]),
            .rd_x_data_o (bank_x_rd[gi])
        );
    end

    assign data_yaxis    = bank_y_rd[~active_bank_q];
    assign data_xaxis    = bank_x_rd[~active_bank_q];
    assign start_sending = (ho_q == HO_HOLD);
    assign running       = (ctrl_q == CTRL_RUN);
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_projection_histogram.sv
// Bench for projection_histogram: a behavioural frame/handoff model checked
// against the DUT every cycle, directed scenarios with literal expectations,
// and a second long-frame instance used to drive a bin into saturation.
`timescale 1ns/1ps
module tb_projection_histogram;

    localparam int FC   = 256;
    localparam int HOLD = 130;
    localparam int FC2  = 66000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        reset = 1'b1;
    logic        event_valid = 1'b0;
    logic [6:0]  event_y = '0, event_x = '0;
    logic [15:0] command = '0;
    logic [6:0]  ry = '0, rx = '0;
    logic [15:0] dy, dx, fcount;
    logic        ss, run;

    // Saturation instance
    logic        reset2 = 1'b1;
    logic        ev2 = 1'b0;
    logic [6:0]  y2 = 7'd3, x2 = 7'd9;
    logic [15:0] cmd2 = '0;
    logic [6:0]  ry2 = 7'd3, rx2 = 7'd9;
    logic [15:0] dy2, dx2, fc2;
    logic        ss2, run2;
    bit          done2 = 1'b0;

    projection_histogram #(.FRAME_CYCLES(FC), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .event_valid(event_valid),
        .event_y(event_y), .event_x(event_x), .command(command),
        .read_index_yaxis(ry), .read_index_xaxis(rx),
        .data_yaxis(dy), .data_xaxis(dx), .start_sending(ss),
        .running(run), .frame_count(fcount)
    );

    projection_histogram #(.FRAME_CYCLES(FC2), .HOLD_CYCLES(HOLD)) dut_sat (
        .clk(clk), .reset(reset2), .event_valid(ev2),
        .event_y(y2), .event_x(x2), .command(cmd2),
        .read_index_yaxis(ry2), .read_index_xaxis(rx2),
        .data_yaxis(dy2), .data_xaxis(dx2), .start_sending(ss2),
        .running(run2), .frame_count(fc2)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model of the main instance ----------------
    int          m_act_y [128];
    int          m_act_x [128];
    int          m_frz_y [128];
    int          m_frz_x [128];
    bit          m_running = 1'b0;
    int          m_fcnt = 0;
    int          m_hold_left = 0;
    bit          m_clear_pending = 1'b0;
    int          m_frame_count = 0;
    logic [15:0] m_prev = '0;

    task automatic model_step();
        bit st, sp;
        if (reset) begin
            for (int i = 0; i < 128; i++) begin
                m_act_y[i] = 0; m_act_x[i] = 0; m_frz_y[i] = 0; m_frz_x[i] = 0;
            end
            m_running = 1'b0; m_fcnt = 0; m_hold_left = 0;
            m_clear_pending = 1'b0; m_frame_count = 0; m_prev = '0;
            return;
        end
        // handoff: start_sending is high while m_hold_left > 0, then one wipe cycle
        if (m_clear_pending) begin
            for (int i = 0; i < 128; i++) begin m_frz_y[i] = 0; m_frz_x[i] = 0; end
            m_clear_pending = 1'b0;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_clear_pending = 1'b1;
        end
        st = (command != m_prev) && (command == 16'd1);
        sp = (command != m_prev) && (command == 16'd2);
        m_prev = command;
        if (st) begin
            m_running = 1'b1; m_fcnt = 0; m_frame_count = 0;
            for (int i = 0; i < 128; i++) begin m_act_y[i] = 0; m_act_x[i] = 0; end
        end else if (sp && m_running) begin
            m_running = 1'b0; m_fcnt = 0;
            for (int i = 0; i < 128; i++) begin m_act_y[i] = 0; m_act_x[i] = 0; end
        end else if (m_running) begin
            if (event_valid) begin
                if (m_act_y[event_y] < 65535) m_act_y[event_y]++;
                if (m_act_x[event_x] < 65535) m_act_x[event_x]++;
            end
            if (m_fcnt == FC - 1) begin
                for (int i = 0; i < 128; i++) begin
                    m_frz_y[i] = m_act_y[i]; m_frz_x[i] = m_act_x[i];
                    m_act_y[i] = 0; m_act_x[i] = 0;
                end
                m_frame_count = (m_frame_count + 1) % 65536;
                m_hold_left = HOLD;
                m_fcnt = 0;
            end else begin
                m_fcnt++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare against the model ----------------
    bit cmp_en = 1'b0;
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("start_sending", ss, (m_hold_left > 0));
            chk("running", run, m_running);
            chk("frame_count", fcount, m_frame_count);
            chk("data_yaxis", dy, m_frz_y[ry]);
            chk("data_xaxis", dx, m_frz_x[rx]);
        end
    end

    task automatic wait_ss(input string name, input logic level, input int bound);
        int n = 0;
        while (ss !== level && n < bound) begin tick(); n++; end
        if (ss !== level) chk({name, "_timeout"}, ss, level);
    endtask

    task automatic rand_ev(input int ylo, input int yhi, input int xlo, input int xhi);
        event_valid = 1'($urandom_range(0, 1));
        event_y = 7'($urandom_range(ylo, yhi));
        event_x = 7'($urandom_range(xlo, xhi));
        ry = 7'($urandom_range(ylo, yhi));
        rx = 7'($urandom_range(xlo, xhi));
    endtask

    // ---------------- main scenario ----------------
    initial begin
        int n, nz;
        // reset
        tick();
        cmp_en = 1'b1;
        tick(); tick();
        ry = 7'd5; rx = 7'd127;
        chk("rst_start_sending", ss, 1'b0);
        chk("rst_running", run, 1'b0);
        chk("rst_frame_count", fcount, 16'd0);
        chk("rst_data_y", dy, 16'd0);
        chk("rst_data_x", dx, 16'd0);
        reset = 1'b0;

        // 10 hits at (5,127) in the first frame
        command = 16'd1;
        tick();
        for (int i = 0; i < 10; i++) begin
            event_valid = 1'b1; event_y = 7'd5; event_x = 7'd127;
            tick();
        end
        event_valid = 1'b0;
        wait_ss("first_frame", 1'b1, 400);
        chk("f1_frame_count", fcount, 16'd1);
        chk("f1_bin_y5", dy, 16'd10);
        chk("f1_bin_x127", dx, 16'd10);
        n = 0;
        while (ss === 1'b1 && n < 1000) begin
            ry = 7'($urandom_range(0, 127));
            rx = 7'($urandom_range(0, 127));
            n++;
            tick();
        end
        chk("hold_length", n, HOLD);
        $display("frame 1 handed off: hold window %0d cycles", n);

        // random traffic over a few frames
        for (int c = 0; c < 3 * FC; c++) begin
            rand_ev(0, 7, 120, 127);
            tick();
        end
        event_valid = 1'b0;
        $display("random traffic done, frame_count=%0d", fcount);

        // hit on the last frame cycle vs. the first cycle of the next frame
        command = 16'd0; tick();
        command = 16'd1; tick();
        n = 0;
        while (m_fcnt != FC - 1 && n < 400) begin tick(); n++; end
        if (m_fcnt != FC - 1) chk("align_timeout", m_fcnt, FC - 1);
        event_valid = 1'b1; event_y = 7'd20; event_x = 7'd30;
        tick();
        event_valid = 1'b1; event_y = 7'd21; event_x = 7'd31;
        tick();
        event_valid = 1'b0;
        chk("boundary_ss", ss, 1'b1);
        ry = 7'd20; rx = 7'd30; #1;
        chk("last_cycle_hit_y", dy, 16'd1);
        chk("last_cycle_hit_x", dx, 16'd1);
        ry = 7'd21; rx = 7'd31; #1;
        chk("next_cycle_not_frozen_y", dy, 16'd0);
        chk("next_cycle_not_frozen_x", dx, 16'd0);
        wait_ss("boundary_hold_end", 1'b0, 300);
        wait_ss("boundary_next", 1'b1, 400);
        ry = 7'd21; rx = 7'd31; #1;
        chk("next_frame_hit_y", dy, 16'd1);
        chk("next_frame_hit_x", dx, 16'd1);
        ry = 7'd20; #1;
        chk("next_frame_old_y", dy, 16'd0);
        $display("frame boundary hits placed, frame_count=%0d", fcount);

        // STOP at cycle 100 of a frame (handoff still in progress)
        n = 0;
        while (m_fcnt != 100 && n < 400) begin rand_ev(0, 7, 0, 7); tick(); n++; end
        rand_ev(0, 7, 0, 7);
        command = 16'd2;
        tick();
        chk("stop_frame_count", fcount, 16'd2);
        chk("stop_running", run, 1'b0);
        wait_ss("stop_hold_end", 1'b0, 200);
        n = 0;
        for (int c = 0; c < 400; c++) begin
            rand_ev(0, 7, 0, 7);
            if (ss === 1'b1) n++;
            tick();
        end
        event_valid = 1'b0;
        chk("stop_no_handoff", n, 0);
        chk("stop_frame_count_kept", fcount, 16'd2);
        command = 16'd1;
        tick();
        wait_ss("after_stop_frame", 1'b1, 400);
        nz = 0;
        for (int i = 0; i < 128; i++) begin
            ry = 7'(i); rx = 7'(i); #1;
            if (dy !== 16'd0 || dx !== 16'd0) nz++;
            tick();
        end
        chk("restart_bins_zero", nz, 0);
        $display("STOP discarded partial frame, restart frame empty");

        // level-held command: one START only; 1->0->1 gives a second START
        command = 16'd0; tick();
        command = 16'd1; tick();
        for (int c = 0; c < 1000; c++) begin rand_ev(0, 127, 0, 127); tick(); end
        chk("held_start_frames", fcount, 16'd3);
        command = 16'd0; tick();
        chk("noop_keeps_count", fcount, 16'd3);
        command = 16'd1; tick();
        chk("second_start_count", fcount, 16'd0);
        chk("second_start_running", run, 1'b1);
        $display("command edge detection exercised");

        // reset in the middle of a hold window
        wait_ss("pre_reset_frame", 1'b1, 400);
        for (int c = 0; c < 50; c++) begin rand_ev(0, 127, 0, 127); tick(); end
        reset = 1'b1; command = 16'd0; event_valid = 1'b0;
        tick();
        chk("reset_mid_hold_ss", ss, 1'b0);
        chk("reset_mid_hold_running", run, 1'b0);
        chk("reset_mid_hold_fc", fcount, 16'd0);
        reset = 1'b0;
        nz = 0;
        for (int i = 0; i < 128; i++) begin
            ry = 7'(i); rx = 7'(127 - i); #1;
            if (dy !== 16'd0 || dx !== 16'd0) nz++;
            tick();
        end
        chk("reset_bins_zero", nz, 0);
        $display("reset during handoff exercised");

        n = 0;
        while (!done2 && n < 80000) begin tick(); n++; end
        if (!done2) chk("saturation_timeout", done2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- saturation scenario on the long-frame instance ----------------
    initial begin
        int n;
        tick(); tick(); tick();
        reset2 = 1'b0;
        cmd2 = 16'd1;
        tick();
        for (int i = 0; i < 65600; i++) begin
            ev2 = 1'b1;
            y2 = (i == 100 || i == 200) ? 7'd4 : 7'd3;
            x2 = 7'd9;
            tick();
        end
        ev2 = 1'b0;
        n = 0;
        while (ss2 !== 1'b1 && n < 2000) begin tick(); n++; end
        chk("sat_handoff", ss2, 1'b1);
        ry2 = 7'd3; rx2 = 7'd9; #1;
        chk("sat_bin_y3", dy2, 16'hFFFF);
        chk("sat_bin_x9", dx2, 16'hFFFF);
        ry2 = 7'd4; rx2 = 7'd0; #1;
        chk("sat_bin_y4", dy2, 16'd2);
        chk("sat_bin_x0", dx2, 16'd0);
        chk("sat_frame_count", fc2, 16'd1);
        $display("saturation frame handed off");
        done2 = 1'b1;
    end

endmodule
